// File: rtl/isp_seq_pkg.sv
// Shared definitions for the ISP frame sequencer: state encoding and error bit positions.
package isp_seq_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ERR_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle    = 3'd0,
        StWaitSof = 3'd1,
        StActive  = 3'd2,
        StDrain   = 3'd3,
        StCommit  = 3'd4,
        StSkip    = 3'd5
    } isp_seq_state_e;

    // Plain-vector aliases so the state register stays a bare logic vector.
    localparam logic [STATE_W-1:0] ST_IDLE     = StIdle;
    localparam logic [STATE_W-1:0] ST_WAIT_SOF = StWaitSof;
    localparam logic [STATE_W-1:0] ST_ACTIVE   = StActive;
    localparam logic [STATE_W-1:0] ST_DRAIN    = StDrain;
    localparam logic [STATE_W-1:0] ST_COMMIT   = StCommit;
    localparam logic [STATE_W-1:0] ST_SKIP     = StSkip;

    localparam int unsigned ERR_SOF   = 0;
    localparam int unsigned ERR_STALL = 1;
    localparam int unsigned ERR_DRAIN = 2;

endpackage

// File: rtl/isp_seq_watchdog.sv
// Generic down-counting watchdog: load arms it, clear disarms it, expires when an armed count hits 0.
module isp_seq_watchdog
    import isp_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_pixel_i,
    input  logic             rst_pixel_n_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    // Clear beats load beats decrement; the count saturates at zero.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (clr_i) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (load_i) begin
            cnt_d   = load_val_i;
            armed_d = 1'b1;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk_pixel_i or negedge rst_pixel_n_i) begin
        if (!rst_pixel_n_i) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign expired_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/isp_frame_seq_ctrl.sv
// Frame-level sequencer: gates pixel entry on frame boundaries, drains after EOF, then
// commits pending shadow configuration between frames and flags protocol faults.
// Build option ISP_FRAME_SKIP_EN: drop cfg_skip_i frames after a config load.
module isp_frame_seq_ctrl
    import isp_seq_pkg::*;
#(
    parameter int unsigned FRAME_CNT_W = 16,
    parameter int unsigned TIMEOUT_W   = 24,
    parameter int unsigned DRAIN_MAX   = 4096
) (
    input  logic                   clk_pixel_i,
    input  logic                   rst_pixel_n_i,
    input  logic                   enable_i,
    input  logic                   upd_req_i,
    input  logic [TIMEOUT_W-1:0]   cfg_timeout_i,
    input  logic [3:0]             cfg_skip_i,
    input  logic                   in_sof_i,
    input  logic                   in_eof_i,
    input  logic                   in_valid_i,
    input  logic                   out_eof_i,
    output logic                   pipe_en_o,
    output logic                   shadow_load_o,
    output logic                   upd_ack_o,
    output logic                   busy_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic [31:0]            frame_pix_o,
    output logic                   drop_o,
    output logic [ERR_W-1:0]       err_o,
    input  logic                   err_clr_i,
    output logic [STATE_W-1:0]     state_o
);

    localparam int unsigned        DRAIN_W    = $clog2(DRAIN_MAX + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_MAX - 1);

    logic [STATE_W-1:0]     state_q, state_d;
    logic [31:0]            pix_cnt_q, pix_cnt_d;
    logic [31:0]            pix_inc, pix_next;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [31:0]            frame_pix_q, frame_pix_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic                   pending_q, pending_d;
    logic                   pipe_en_q, pipe_en_d;
    logic                   busy_q, busy_d;
    logic                   shadow_load_q, shadow_load_d;
    logic                   upd_ack_q, upd_ack_d;
    logic                   drop_q, drop_d;
    logic                   commit_load;

    logic stall_load, stall_clr, stall_dec, stall_expired;
    logic drain_load, drain_clr, drain_dec, drain_expired;

`ifdef ISP_FRAME_SKIP_EN
    logic [3:0] skip_cnt_q, skip_cnt_d;
`else
    logic unused_cfg_skip;
    assign unused_cfg_skip = ^cfg_skip_i;
`endif

    assign pix_inc     = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + 32'd1;
    assign pix_next    = in_valid_i ? pix_inc : pix_cnt_q;
    // A request landing in the commit cycle itself is folded into that commit.
    assign commit_load = pending_q | upd_req_i;

    // Next-state, counters, error flags and registered-output values.
    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        frame_pix_d   = frame_pix_q;
        err_d         = err_clr_i ? '0 : err_q;
        pending_d     = pending_q | upd_req_i;
        shadow_load_d = 1'b0;
        upd_ack_d     = 1'b0;
        drop_d        = 1'b0;
        stall_load    = 1'b0;
`ifdef ISP_FRAME_SKIP_EN
        skip_cnt_d    = skip_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_COMMIT;
                end else if (enable_i) begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (in_sof_i) begin
                    state_d     = ST_ACTIVE;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    pix_cnt_d   = '0;
                    stall_load  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // enable_i is deliberately ignored here so a frame is never cut short.
                if (in_eof_i) begin
                    state_d     = ST_DRAIN;
                    pix_cnt_d   = pix_next;
                    frame_pix_d = pix_next;
                end else if (stall_expired) begin
                    state_d          = ST_DRAIN;
                    err_d[ERR_STALL] = 1'b1;
                    frame_pix_d      = pix_next;
                end else if (in_sof_i) begin
                    err_d[ERR_SOF] = 1'b1;
                    frame_cnt_d    = frame_cnt_q + FRAME_CNT_W'(1);
                    pix_cnt_d      = '0;
                    stall_load     = 1'b1;
                end else begin
                    pix_cnt_d  = pix_next;
                    stall_load = in_valid_i;
                end
            end
            ST_DRAIN: begin
                drop_d = in_sof_i;
                if (out_eof_i) begin
                    state_d = ST_COMMIT;
                end else if (drain_expired) begin
                    state_d          = ST_COMMIT;
                    err_d[ERR_DRAIN] = 1'b1;
                end
            end
            ST_COMMIT: begin
                drop_d        = in_sof_i;
                shadow_load_d = commit_load;
                upd_ack_d     = commit_load;
                pending_d     = 1'b0;
`ifdef ISP_FRAME_SKIP_EN
                if (commit_load && (cfg_skip_i != '0)) begin
                    state_d    = ST_SKIP;
                    skip_cnt_d = cfg_skip_i;
                end else begin
                    state_d = enable_i ? ST_WAIT_SOF : ST_IDLE;
                end
`else
                state_d = enable_i ? ST_WAIT_SOF : ST_IDLE;
`endif
            end
`ifdef ISP_FRAME_SKIP_EN
            ST_SKIP: begin
                drop_d = in_sof_i;
                if (skip_cnt_q == '0) begin
                    state_d = enable_i ? ST_WAIT_SOF : ST_IDLE;
                end else if (in_eof_i) begin
                    skip_cnt_d = skip_cnt_q - 4'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pipe_en_d = (state_d == ST_ACTIVE);
        busy_d    = (state_d != ST_IDLE);
    end

    // Stall watchdog only runs while the frame stays active with a non-zero timeout.
    assign stall_clr = (cfg_timeout_i == '0) || (state_d != ST_ACTIVE);
    assign stall_dec = (state_q == ST_ACTIVE);

    // Drain watchdog is armed on DRAIN entry and gives DRAIN_MAX cycles for out_eof_i.
    assign drain_load = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);
    assign drain_clr  = (state_d != ST_DRAIN);
    assign drain_dec  = (state_q == ST_DRAIN);

    isp_seq_watchdog #(
        .CNT_W (TIMEOUT_W)
    ) u_stall_wdog (
        .clk_pixel_i   (clk_pixel_i),
        .rst_pixel_n_i (rst_pixel_n_i),
        .clr_i         (stall_clr),
        .load_i        (stall_load),
        .load_val_i    (cfg_timeout_i),
        .dec_i         (stall_dec),
        .expired_o     (stall_expired)
    );

    isp_seq_watchdog #(
        .CNT_W (DRAIN_W)
    ) u_drain_wdog (
        .clk_pixel_i   (clk_pixel_i),
        .rst_pixel_n_i (rst_pixel_n_i),
        .clr_i         (drain_clr),
        .load_i        (drain_load),
        .load_val_i    (DRAIN_LOAD),
        .dec_i         (drain_dec),
        .expired_o     (drain_expired)
    );

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk_pixel_i or negedge rst_pixel_n_i) begin
        if (!rst_pixel_n_i) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            frame_pix_q   <= '0;
            err_q         <= '0;
            pending_q     <= 1'b0;
            pipe_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            shadow_load_q <= 1'b0;
            upd_ack_q     <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_pix_q   <= frame_pix_d;
            err_q         <= err_d;
            pending_q     <= pending_d;
            pipe_en_q     <= pipe_en_d;
            busy_q        <= busy_d;
            shadow_load_q <= shadow_load_d;
            upd_ack_q     <= upd_ack_d;
            drop_q        <= drop_d;
        end
    end

`ifdef ISP_FRAME_SKIP_EN
    // Remaining frames to discard after a config load.
    always_ff @(posedge clk_pixel_i or negedge rst_pixel_n_i) begin
        if (!rst_pixel_n_i) begin
            skip_cnt_q <= '0;
        end else begin
            skip_cnt_q <= skip_cnt_d;
        end
    end
`endif

    assign pipe_en_o     = pipe_en_q;
    assign shadow_load_o = shadow_load_q;
    assign upd_ack_o     = upd_ack_q;
    assign busy_o        = busy_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign frame_pix_o   = frame_pix_q;
    assign drop_o        = drop_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_isp_frame_seq_ctrl.sv
// Scoreboard bench for isp_frame_seq_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_isp_frame_seq_ctrl;
    import isp_seq_pkg::*;

    localparam int K_PIPE   = 0;
    localparam int K_ERR    = 1;
    localparam int K_COMMIT = 2;
    localparam int K_LOAD   = 3;
    localparam int K_DROP   = 4;

    typedef struct {
        int          kind;
        logic        pipe;
        logic [31:0] pix;
        logic [15:0] cnt;
        logic [2:0]  err;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, upd_req, in_sof, in_eof, in_valid, out_eof, err_clr;
    logic [23:0] cfg_timeout;
    logic [3:0]  cfg_skip;
    logic        pipe_en, shadow_load, upd_ack, busy, drop;
    logic [15:0] frame_cnt;
    logic [31:0] frame_pix;
    logic [2:0]  err;
    logic [2:0]  state;

    always #5 clk = ~clk;

    isp_frame_seq_ctrl #(
        .FRAME_CNT_W (16),
        .TIMEOUT_W   (24),
        .DRAIN_MAX   (4096)
    ) dut (
        .clk_pixel_i   (clk),
        .rst_pixel_n_i (rst_n),
        .enable_i      (enable),
        .upd_req_i     (upd_req),
        .cfg_timeout_i (cfg_timeout),
        .cfg_skip_i    (cfg_skip),
        .in_sof_i      (in_sof),
        .in_eof_i      (in_eof),
        .in_valid_i    (in_valid),
        .out_eof_i     (out_eof),
        .pipe_en_o     (pipe_en),
        .shadow_load_o (shadow_load),
        .upd_ack_o     (upd_ack),
        .busy_o        (busy),
        .frame_cnt_o   (frame_cnt),
        .frame_pix_o   (frame_pix),
        .drop_o        (drop),
        .err_o         (err),
        .err_clr_i     (err_clr),
        .state_o       (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int kind, input logic pipe, input logic [31:0] pix,
                        input logic [15:0] cnt, input logic [2:0] e);
        ev_t ev;
        ev.kind = kind;
        ev.pipe = pipe;
        ev.pix  = pix;
        ev.cnt  = cnt;
        ev.err  = e;
        exp_q.push_back(ev);
    endtask

    task automatic match(input int kind);
        ev_t ev;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected event: kind %0d seen, none expected (t=%0t)", kind, $time);
            return;
        end
        ev = exp_q.pop_front();
        chk("event kind", kind, ev.kind);
        if (ev.kind == kind) begin
            case (kind)
                K_PIPE: begin
                    chk("pipe_en edge", {31'd0, pipe_en}, {31'd0, ev.pipe});
                    chk("frame_pix", frame_pix, ev.pix);
                    chk("frame_cnt at pipe edge", {16'd0, frame_cnt}, {16'd0, ev.cnt});
                end
                K_ERR:    chk("err_o", {29'd0, err}, {29'd0, ev.err});
                K_COMMIT: chk("frame_cnt at commit", {16'd0, frame_cnt}, {16'd0, ev.cnt});
                K_LOAD: begin
                    chk("shadow_load", {31'd0, shadow_load}, 32'd1);
                    chk("upd_ack", {31'd0, upd_ack}, 32'd1);
                    chk("frame_cnt at load", {16'd0, frame_cnt}, {16'd0, ev.cnt});
                end
                default:  chk("frame_cnt at drop", {16'd0, frame_cnt}, {16'd0, ev.cnt});
            endcase
        end
    endtask

    // Monitor: detect output events once per cycle, in a fixed order within a cycle.
    logic       prev_pipe = 1'b0;
    logic [2:0] prev_err  = 3'd0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pipe_en !== prev_pipe)       match(K_PIPE);
            if (err !== prev_err)            match(K_ERR);
            if (state == ST_COMMIT)          match(K_COMMIT);
            if (shadow_load || upd_ack)      match(K_LOAD);
            if (drop)                        match(K_DROP);
        end
        prev_pipe = pipe_en;
        prev_err  = err;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sof();
        in_sof = 1'b1;
        cyc(1);
        in_sof = 1'b0;
    endtask

    task automatic pulse_out_eof();
        out_eof = 1'b1;
        cyc(1);
        out_eof = 1'b0;
    endtask

    task automatic beats(input int n, input bit eof_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_eof   = eof_last && (i == n - 1);
            cyc(1);
        end
        in_valid = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input bit leave, input int budget,
                              input string name, output int waited);
        waited = 0;
        while (((state === st) == leave) && waited < budget) begin
            cyc(1);
            waited++;
        end
        n_cmp++;
        if (waited >= budget) begin
            n_bad++;
            $display("FAIL %s: state 0x%0h after %0d cycles", name, state, waited);
        end
    endtask

    int          w;
    logic [15:0] ecnt;
    logic [31:0] epix;

    initial begin
        $timeformat(-9, 0, " ns", 8);
        #2_000_000;
        $display("FAIL global timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; upd_req = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        in_valid = 1'b0; out_eof = 1'b0; err_clr = 1'b0; cfg_timeout = 24'd0; cfg_skip = 4'd0;
        ecnt = 16'd0;
        epix = 32'd0;
        cyc(3);
        chk("reset pipe_en", {31'd0, pipe_en}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset state", {29'd0, state}, 32'd0);
        chk("reset frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("reset frame_pix", frame_pix, 32'd0);
        chk("reset err", {29'd0, err}, 32'd0);
        chk("reset strobes", {29'd0, shadow_load, upd_ack, drop}, 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Basic frame: 100 beats, EOF on the last beat, drain closed by out_eof after 20 cycles.
        ecnt = 16'd1;
        push(K_PIPE, 1'b1, epix, ecnt, 3'd0);
        epix = 32'd100;
        push(K_PIPE, 1'b0, epix, ecnt, 3'd0);
        push(K_COMMIT, 1'b0, 32'd0, ecnt, 3'd0);
        enable = 1'b1;
        cyc(1);
        chk("enable -> WAIT_SOF", {29'd0, state}, {29'd0, ST_WAIT_SOF});
        chk("busy in WAIT_SOF", {31'd0, busy}, 32'd1);
        pulse_sof();
        beats(100, 1'b1);
        cyc(20);
        pulse_out_eof();
        cyc(1);
        chk("commit -> WAIT_SOF", {29'd0, state}, {29'd0, ST_WAIT_SOF});

        // Two update requests mid-frame coalesce into one load after the commit.
        ecnt = 16'd2;
        push(K_PIPE, 1'b1, epix, ecnt, 3'd0);
        epix = 32'd10;
        push(K_PIPE, 1'b0, epix, ecnt, 3'd0);
        push(K_COMMIT, 1'b0, 32'd0, ecnt, 3'd0);
        push(K_LOAD, 1'b0, 32'd0, ecnt, 3'd0);
        pulse_sof();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            upd_req  = (i == 2) || (i == 6);
            cyc(1);
        end
        in_valid = 1'b0;
        upd_req  = 1'b0;
        in_eof   = 1'b1;
        cyc(1);
        in_eof   = 1'b0;
        cyc(5);
        pulse_out_eof();
        cyc(3);

        // Missing EOF: second SOF flags err[0], bumps the frame count, restarts pixel count.
        ecnt = 16'd3;
        push(K_PIPE, 1'b1, epix, ecnt, 3'd0);
        push(K_ERR, 1'b0, 32'd0, 16'd0, 3'b001);
        push(K_ERR, 1'b0, 32'd0, 16'd0, 3'b000);
        epix = 32'd5;
        push(K_PIPE, 1'b0, epix, 16'd4, 3'd0);
        push(K_COMMIT, 1'b0, 32'd0, 16'd4, 3'd0);
        pulse_sof();
        beats(50, 1'b0);
        pulse_sof();
        ecnt = 16'd4;
        chk("stays ACTIVE on SOF", {29'd0, state}, {29'd0, ST_ACTIVE});
        chk("frame_cnt after SOF", {16'd0, frame_cnt}, {16'd0, ecnt});
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        beats(5, 1'b1);
        cyc(3);
        pulse_out_eof();
        cyc(1);

        // Stall timeout then drain timeout.
        cfg_timeout = 24'd10;
        ecnt = 16'd5;
        push(K_PIPE, 1'b1, epix, ecnt, 3'd0);
        epix = 32'd3;
        push(K_PIPE, 1'b0, epix, ecnt, 3'd0);
        push(K_ERR, 1'b0, 32'd0, 16'd0, 3'b010);
        push(K_ERR, 1'b0, 32'd0, 16'd0, 3'b110);
        push(K_COMMIT, 1'b0, 32'd0, ecnt, 3'd0);
        pulse_sof();
        beats(3, 1'b0);
        wait_state(ST_DRAIN, 1'b0, 40, "stall -> DRAIN", w);
        chk("stall cycles to DRAIN", w, 32'd11);
        wait_state(ST_DRAIN, 1'b1, 5000, "drain timeout", w);
        chk("drain cycles", w, 32'd4096);
        chk("drain timeout -> COMMIT", {29'd0, state}, {29'd0, ST_COMMIT});
        cfg_timeout = 24'd0;
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        push(K_ERR, 1'b0, 32'd0, 16'd0, 3'b000);
        cyc(1);

        // Disable mid-frame, SOF in DRAIN dropped, request in the COMMIT cycle serviced.
        ecnt = 16'd6;
        push(K_PIPE, 1'b1, epix, ecnt, 3'd0);
        epix = 32'd5;
        push(K_PIPE, 1'b0, epix, ecnt, 3'd0);
        push(K_DROP, 1'b0, 32'd0, ecnt, 3'd0);
        push(K_COMMIT, 1'b0, 32'd0, ecnt, 3'd0);
        push(K_LOAD, 1'b0, 32'd0, ecnt, 3'd0);
        pulse_sof();
        beats(2, 1'b0);
        enable = 1'b0;
        beats(2, 1'b0);
        chk("no abort on disable", {29'd0, state}, {29'd0, ST_ACTIVE});
        beats(1, 1'b1);
        cyc(2);
        pulse_sof();
        cyc(2);
        pulse_out_eof();
        upd_req = 1'b1;
        cyc(1);
        upd_req = 1'b0;
        cyc(5);
        chk("IDLE after commit", {29'd0, state}, {29'd0, ST_IDLE});
        chk("busy in IDLE", {31'd0, busy}, 32'd0);

        // Update request while idle commits without a frame.
        push(K_COMMIT, 1'b0, 32'd0, ecnt, 3'd0);
        push(K_LOAD, 1'b0, 32'd0, ecnt, 3'd0);
        upd_req = 1'b1;
        cyc(1);
        upd_req = 1'b0;
        cyc(6);
        chk("IDLE after idle commit", {29'd0, state}, {29'd0, ST_IDLE});

`ifdef ISP_FRAME_SKIP_EN
        // Two frames skipped after a load, the third one accepted.
        cfg_skip = 4'd2;
        push(K_COMMIT, 1'b0, 32'd0, ecnt, 3'd0);
        push(K_LOAD, 1'b0, 32'd0, ecnt, 3'd0);
        push(K_DROP, 1'b0, 32'd0, ecnt, 3'd0);
        push(K_DROP, 1'b0, 32'd0, ecnt, 3'd0);
        ecnt = ecnt + 16'd1;
        push(K_PIPE, 1'b1, epix, ecnt, 3'd0);
        epix = 32'd2;
        push(K_PIPE, 1'b0, epix, ecnt, 3'd0);
        push(K_COMMIT, 1'b0, 32'd0, ecnt, 3'd0);
        upd_req = 1'b1;
        cyc(1);
        upd_req = 1'b0;
        enable  = 1'b1;
        cyc(3);
        chk("in SKIP", {29'd0, state}, {29'd0, ST_SKIP});
        pulse_sof();
        beats(3, 1'b1);
        cyc(1);
        pulse_sof();
        beats(3, 1'b1);
        cyc(2);
        chk("skip done -> WAIT_SOF", {29'd0, state}, {29'd0, ST_WAIT_SOF});
        cfg_skip = 4'd0;
        pulse_sof();
        beats(2, 1'b1);
        cyc(2);
        pulse_out_eof();
        cyc(1);
`endif

        // Reset mid-frame with a pending update: update is lost.
        enable = 1'b1;
        cyc(2);
        push(K_PIPE, 1'b1, epix, ecnt + 16'd1, 3'd0);
        pulse_sof();
        beats(3, 1'b0);
        upd_req = 1'b1;
        cyc(1);
        upd_req = 1'b0;
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("async reset pipe_en", {31'd0, pipe_en}, 32'd0);
        chk("async reset state", {29'd0, state}, 32'd0);
        cyc(2);
        enable = 1'b0;
        rst_n  = 1'b1;
        cyc(6);
        chk("IDLE after reset, no commit", {29'd0, state}, {29'd0, ST_IDLE});
        chk("frame_cnt after reset", {16'd0, frame_cnt}, 32'd0);

        cyc(2);
        chk("unmatched expected events", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/isp_frame_seq_ctrl.md
Name: isp_frame_seq_ctrl

Overview:
- Frame-level sequencer for the ISP pixel pipeline.
- Gates raw pixel entry into the pipeline (bayer processing through the output formatter) on frame boundaries.
- Drains the pipeline after each end-of-frame, then issues a single-cycle shadow-register load so new configuration takes effect only between frames.
- Detects protocol faults (missing EOF, stalled input, drain hang) and reports per-frame pixel count and frame number.

Parameters:
- FRAME_CNT_W, 16, frame counter width.
- TIMEOUT_W, 24, width of the input-stall timeout counter.
- DRAIN_MAX, 4096, maximum cycles to wait for output EOF in DRAIN.

Ports:
- clk_pixel_i  in  1  pixel clock.
- rst_pixel_n_i  in  1  reset; asynchronous, active-low.
- enable_i  in  1  run request, level, pixel-domain synchronous.
- upd_req_i  in  1  config update request pulse, already synchronised.
- cfg_timeout_i  in  TIMEOUT_W  stall timeout in cycles; 0 disables.
- cfg_skip_i  in  4  frames to drop after a load (feature only).
- in_sof_i  in  1  raw stream start-of-frame.
- in_eof_i  in  1  raw stream end-of-frame.
- in_valid_i  in  1  raw pixel valid.
- out_eof_i  in  1  output formatter frame-end.
- pipe_en_o  out  1  pixel gate into the pipeline.
- shadow_load_o  out  1  one-cycle shadow register load strobe.
- upd_ack_o  out  1  one-cycle acknowledge of a serviced update.
- busy_o  out  1  state != IDLE.
- frame_cnt_o  out  FRAME_CNT_W  accepted frames, wraps.
- frame_pix_o  out  32  pixel count of the last completed frame.
- drop_o  out  1  one-cycle pulse when a SOF is rejected.
- err_o  out  3  sticky errors {drain_to, stall_to, sof_in_active}.
- err_clr_i  in  1  clears err_o.
- state_o  out  3  current state encoding.

Behaviour:
- Reset: all outputs 0; state IDLE; pending flag 0; all counters 0.
- All outputs are registered.
- States: IDLE=0, WAIT_SOF=1, ACTIVE=2, DRAIN=3, COMMIT=4, SKIP=5.
- IDLE:
  - pending=1 -> COMMIT.
  - Else enable_i=1 -> WAIT_SOF.
- WAIT_SOF:
  - enable_i=0 -> IDLE.
  - in_sof_i=1 -> ACTIVE. pipe_en_o rises the same edge, so the SOF beat itself is passed; frame_cnt increments; pixel counter and stall counter load 0.
- ACTIVE:
  - pipe_en_o=1.
  - in_valid_i increments the pixel counter, saturating at 0xFFFFFFFF.
  - in_eof_i -> DRAIN; frame_pix_o latches the count including an EOF-coincident valid beat.
  - in_sof_i without a prior EOF: set err_o[0], increment frame_cnt, restart the pixel count, stay ACTIVE.
  - Stall counter clears on in_valid_i and counts otherwise. When cfg_timeout_i!=0 and count==cfg_timeout_i: set err_o[1], latch frame_pix_o, go to DRAIN.
- DRAIN:
  - pipe_en_o=0.
  - out_eof_i -> COMMIT.
  - After DRAIN_MAX cycles without out_eof_i: set err_o[2], go to COMMIT.
  - in_sof_i here or in COMMIT: drop_o pulses; that frame is not entered.
- COMMIT (exactly one cycle):
  - If pending, shadow_load_o=1 and upd_ack_o=1, and pending clears.
  - Next state: SKIP if (feature built, a load occurred, cfg_skip_i!=0); else WAIT_SOF if enable_i; else IDLE.
- Pending flag:
  - Set by upd_req_i.
  - A request arriving in the COMMIT cycle is serviced by that commit; pending ends 0.
  - Multiple requests coalesce into a single ack.
- Disable: enable_i falling during ACTIVE does not abort the frame; the block finishes ACTIVE -> DRAIN -> COMMIT, then goes to IDLE.
- Error bits:
  - err_o bits are sticky.
  - err_clr_i clears all bits; a set in the same cycle wins.
- Reset mid-frame: immediate return to IDLE with pipe_en_o=0; the pending update is lost.

Optional Feature:
- Macro: ISP_FRAME_SKIP_EN.
- With the macro:
  - SKIP state exists and loads skip_cnt=cfg_skip_i on entry.
  - In SKIP, pipe_en_o=0; each in_eof_i decrements skip_cnt, and each SOF pulses drop_o.
  - At skip_cnt==0, go to WAIT_SOF, or to IDLE if enable_i=0.
  - Purpose: let AE/AWB settle after a config change.
- Without the macro: SKIP is unreachable and cfg_skip_i is ignored; the port stays for a uniform interface.

Decomposition:
- isp_seq_pkg holds:
  - state enum isp_seq_state_e;
  - err bit index constants ERR_SOF, ERR_STALL, ERR_DRAIN;
  - state encoding widths.
- One sub-module, isp_seq_watchdog: a generic load/clear/compare down-counter used for both stall and drain timeouts, instantiated twice.

Test Plan:
- Basic frame: enable, SOF, 100 valid beats, EOF, out_eof_i after 20 cycles, no update request -> pipe_en_o high for exactly the active window, frame_pix_o=100, frame_cnt_o=1, shadow_load_o never pulses.
- Update mid-frame: upd_req_i pulsed twice during ACTIVE -> exactly one shadow_load_o/upd_ack_o pulse, in the COMMIT cycle after out_eof_i.
- Missing EOF: SOF, 50 beats, SOF -> err_o=3'b001, frame_cnt_o=2, state stays ACTIVE; err_clr_i -> err_o=0.
- Stall: cfg_timeout_i=10, no valid beats for 10 cycles in ACTIVE -> err_o[1]=1, DRAIN entered; no out_eof_i for 4096 cycles -> err_o[2]=1, COMMIT.
- SOF during DRAIN -> drop_o pulses once, frame_cnt_o unchanged; disable during ACTIVE -> IDLE only after COMMIT.
- With ISP_FRAME_SKIP_EN, cfg_skip_i=2, update committed -> next two frames dropped with pipe_en_o=0; the third frame is accepted.
